// File: rtl/tft_framebuffer_arbiter.sv
// tft_framebuffer_arbiter: shares one single-port 16-bit framebuffer RAM between the TFT
// pixel prefetcher and a pixel writer. Display fetches run in raster order with wrap-around
// and feed a small prefetch FIFO whose head is presented on disp_data_o.
// Optional feature macro: TFT_FB_UNDERRUN_CNT_EN adds underrun_cnt_o (saturating) and
// underrun_clr_i (synchronous clear, wins over a same-cycle increment).
module tft_framebuffer_arbiter #(
    parameter int unsigned WIDTH     = 320,
    parameter int unsigned HEIGHT    = 240,
    parameter int unsigned ADDR_W    = 17,
    parameter int unsigned PF_DEPTH  = 4,
    parameter int unsigned LOW_WATER = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              disp_clk_i,
    output logic [15:0]       disp_data_o,
    output logic              frame_start_o,
    output logic              underrun_o,
`ifdef TFT_FB_UNDERRUN_CNT_EN
    output logic [15:0]       underrun_cnt_o,
    input  logic              underrun_clr_i,
`endif
    input  logic              wr_valid_i,
    output logic              wr_ready_o,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [15:0]       wr_data_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic              ram_we_o,
    output logic [15:0]       ram_wdata_o,
    input  logic [15:0]       ram_rdata_i
);
    localparam int unsigned NPIX = WIDTH * HEIGHT;
    localparam int unsigned PTR_W = (PF_DEPTH > 1) ? $clog2(PF_DEPTH) : 1;
    localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(NPIX - 1);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(PF_DEPTH - 1);
    localparam logic [3:0] LOW_WATER_C = 4'(LOW_WATER);
    localparam logic [3:0] DEPTH_C = 4'(PF_DEPTH);

    logic              disp_meta_q, disp_sync_q, disp_prev_q;
    logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_W-1:0] disp_idx_q, disp_idx_d;
    logic              inflight_q;
    logic [7:0]        drop_cnt_q, drop_cnt_d;
    logic [15:0]       fifo_q [PF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, wr_ptr_q;
    logic [3:0]        count_q, count_d, occ;
    logic [15:0]       disp_data_q;
    logic              frame_start_q, underrun_q;
    logic              advance, fifo_empty, pop, under, discard, push;
    logic              fetch_go, wr_go, wr_in_range;

    assign advance     = disp_sync_q & ~disp_prev_q;
    assign occ         = count_q + {3'b000, inflight_q};
    assign fetch_go    = (occ < LOW_WATER_C) | (~wr_valid_i & (occ < DEPTH_C));
    assign wr_go       = wr_valid_i & (occ >= LOW_WATER_C);
    assign wr_in_range = (wr_addr_i <= LAST_PIX);
    assign fifo_empty  = (count_q == 4'd0);
    assign pop         = advance & ~fifo_empty;
    assign under       = advance & fifo_empty;
    // A read returning in the same cycle as an underrun is the skipped pixel itself.
    assign discard     = inflight_q & ((drop_cnt_q != 8'd0) | under);
    assign push        = inflight_q & ~discard;

    assign wr_ready_o    = wr_go;
    assign ram_we_o      = wr_go & wr_in_range;
    assign ram_addr_o    = wr_go ? wr_addr_i : fetch_addr_q;
    assign ram_wdata_o   = wr_data_i;
    assign disp_data_o   = disp_data_q;
    assign frame_start_o = frame_start_q;
    assign underrun_o    = underrun_q;

    // Next-state for fetch address, display index, FIFO occupancy and pending drops.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        if (fetch_go) begin
            fetch_addr_d = (fetch_addr_q == LAST_PIX) ? '0 : fetch_addr_q + ADDR_W'(1);
        end
        disp_idx_d = disp_idx_q;
        if (advance) begin
            disp_idx_d = (disp_idx_q == LAST_PIX) ? '0 : disp_idx_q + ADDR_W'(1);
        end
        count_d = count_q + {3'b000, push} - {3'b000, pop};
        drop_cnt_d = drop_cnt_q;
        if (under && !discard && drop_cnt_q != 8'hFF) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end else if (!under && discard) begin
            drop_cnt_d = drop_cnt_q - 8'd1;
        end
    end

    // Two-flop synchroniser plus edge history for the display advance clock.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            disp_meta_q <= 1'b0;
            disp_sync_q <= 1'b0;
            disp_prev_q <= 1'b0;
        end else begin
            disp_meta_q <= disp_clk_i;
            disp_sync_q <= disp_meta_q;
            disp_prev_q <= disp_sync_q;
        end
    end

    // Fetch, drop, FIFO pointer and display output state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_addr_q  <= '0;
            disp_idx_q    <= '0;
            inflight_q    <= 1'b0;
            drop_cnt_q    <= 8'd0;
            count_q       <= 4'd0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            disp_data_q   <= 16'h0000;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            fetch_addr_q  <= fetch_addr_d;
            disp_idx_q    <= disp_idx_d;
            inflight_q    <= fetch_go;
            drop_cnt_q    <= drop_cnt_d;
            count_q       <= count_d;
            frame_start_q <= pop & (disp_idx_q == '0);
            underrun_q    <= under;
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                disp_data_q <= fifo_q[rd_ptr_q];
                rd_ptr_q    <= (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // FIFO storage; occupancy gates every read so the array needs no reset.
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= ram_rdata_i;
        end
    end

`ifdef TFT_FB_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q;

    // Saturating underrun counter; clear takes precedence over a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            underrun_cnt_q <= 16'h0000;
        end else if (underrun_clr_i) begin
            underrun_cnt_q <= 16'h0000;
        end else if (under && underrun_cnt_q != 16'hFFFF) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
    end

    assign underrun_cnt_o = underrun_cnt_q;
`endif

endmodule
